// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU through a
// round-robin grant. Each accepted operation is captured into a single
// result slot that a downstream consumer drains with rsp_ready.

`ifndef REG_FILE_WIDTH
`define REG_FILE_WIDTH 32
`endif

module alu_arbiter #(
    parameter int WIDTH = `REG_FILE_WIDTH,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    // requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    // requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    // result slot
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_w,
    output logic             rsp_cmp,
    input  logic             rsp_ready,
    // accepted-request counters
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
);

    // result slot and arbitration state
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_w;
    logic             r_rsp_cmp;
    logic             r_last_grant;
    logic [15:0]      r_cnt0;
    logic [15:0]      r_cnt1;

    // combinational arbitration / datapath
    logic             w_slot_free;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_acc0;
    logic             w_acc1;
    logic [OPW-1:0]   w_alu_op;
    logic [WIDTH-1:0] w_alu_x;
    logic [WIDTH-1:0] w_alu_y;
    logic [WIDTH-1:0] w_alu_w;
    logic             w_alu_cmp;

    // The slot can take a new result if it is empty or being drained now.
    assign w_slot_free = ~r_rsp_valid | rsp_ready;

    // Lone requester wins; on contention the one not granted last wins.
    // r_last_grant resets to 1 so requester 0 wins the first contention.
    assign w_gnt0 = req0_valid & (~req1_valid | r_last_grant);
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last_grant);

    // Grants are mutually exclusive, so at most one ready is ever high.
    // Gating with rst_n keeps both readies low throughout reset.
    assign req0_ready = w_gnt0 & w_slot_free & rst_n;
    assign req1_ready = w_gnt1 & w_slot_free & rst_n;

    assign w_acc0 = req0_valid & req0_ready;
    assign w_acc1 = req1_valid & req1_ready;

    // ALU operand mux: requester 1 only when granted, otherwise requester 0.
    assign w_alu_op = w_gnt1 ? req1_op : req0_op;
    assign w_alu_x  = w_gnt1 ? req1_x  : req0_x;
    assign w_alu_y  = w_gnt1 ? req1_y  : req0_y;

    alu #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .op  (w_alu_op),
        .x   (w_alu_x),
        .y   (w_alu_y),
        .w   (w_alu_w),
        .cmp (w_alu_cmp)
    );

    // Result slot: load on accept (overwrites on simultaneous drain),
    // clear valid on a plain drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_w     <= '0;
            r_rsp_cmp   <= 1'b0;
        end else if (w_acc0 | w_acc1) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_acc1;
            r_rsp_w     <= w_alu_w;
            r_rsp_cmp   <= w_alu_cmp;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves only when a grant is actually accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_acc0) begin
            r_last_grant <= 1'b0;
        end else if (w_acc1) begin
            r_last_grant <= 1'b1;
        end
    end

    // Per-requester accept counters, free-running with natural wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= 16'h0000;
            r_cnt1 <= 16'h0000;
        end else begin
            if (w_acc0) r_cnt0 <= r_cnt0 + 16'd1;
            if (w_acc1) r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_w      = r_rsp_w;
    assign rsp_cmp    = r_rsp_cmp;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

endmodule

// alu: purely combinational integer ALU.
// Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA,
// 8 SLT, 9 SLTU, 10 EQ, 11 NE, 12 GE, 13 GEU, 14 PASS y.
// Compare opcodes raise cmp and also return it zero-extended on w;
// all other opcodes leave cmp low. Unused opcodes yield w=0, cmp=0.
module alu #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] w,
    output logic             cmp
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(5);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(6);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(7);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(8);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(9);
    localparam logic [OPW-1:0] OP_EQ   = OPW'(10);
    localparam logic [OPW-1:0] OP_NE   = OPW'(11);
    localparam logic [OPW-1:0] OP_GE   = OPW'(12);
    localparam logic [OPW-1:0] OP_GEU  = OPW'(13);
    localparam logic [OPW-1:0] OP_PASS = OPW'(14);

    logic [SHW-1:0] w_shamt;
    logic           w_lt_s;
    logic           w_lt_u;
    logic           w_eq;

    // Shift amount uses only the low bits of y, like a typical integer ISA.
    assign w_shamt = y[SHW-1:0];
    assign w_lt_s  = $signed(x) < $signed(y);
    assign w_lt_u  = x < y;
    assign w_eq    = x == y;

    // Opcode decode into result word and compare flag.
    always_comb begin
        w   = '0;
        cmp = 1'b0;
        case (op)
            OP_ADD:  w = x + y;
            OP_SUB:  w = x - y;
            OP_AND:  w = x & y;
            OP_OR:   w = x | y;
            OP_XOR:  w = x ^ y;
            OP_SLL:  w = x << w_shamt;
            OP_SRL:  w = x >> w_shamt;
            OP_SRA:  w = $signed(x) >>> w_shamt;
            OP_SLT:  cmp = w_lt_s;
            OP_SLTU: cmp = w_lt_u;
            OP_EQ:   cmp = w_eq;
            OP_NE:   cmp = ~w_eq;
            OP_GE:   cmp = ~w_lt_s;
            OP_GEU:  cmp = ~w_lt_u;
            OP_PASS: w = y;
            default: begin
                w   = '0;
                cmp = 1'b0;
            end
        endcase
        // Compare results are also returned as a 0/1 word.
        if (op >= OP_SLT && op <= OP_GEU) begin
            w = {{(WIDTH-1){1'b0}}, cmp};
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a random
// stream, all checked against a transaction-level model kept here.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic        rsp_valid, rsp_id, rsp_cmp, rsp_ready;
    logic [31:0] rsp_w;
    logic [15:0] grant_cnt0, grant_cnt1;

    int n_cmp = 0;
    int n_err = 0;

    // model state: result slot, who was accepted last, accept counts
    logic        m_vld;
    logic        m_id;
    logic [31:0] m_w;
    logic        m_cmp;
    int          m_last;
    logic [15:0] m_cnt0, m_cnt1;

    alu_arbiter #(.WIDTH(32), .OPW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x(req1_x), .req1_y(req1_y),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_w(rsp_w), .rsp_cmp(rsp_cmp),
        .rsp_ready(rsp_ready),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clk = ~clk;

    // reference ALU in plain integer arithmetic
    function automatic void alu_ref(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] w, output logic c);
        int sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        w = 32'd0;
        c = 1'b0;
        case (op)
            5'd0:  w = x + y;
            5'd1:  w = x - y;
            5'd2:  w = x & y;
            5'd3:  w = x | y;
            5'd4:  w = x ^ y;
            5'd5:  w = x << y[4:0];
            5'd6:  w = x >> y[4:0];
            5'd7:  w = sx >>> y[4:0];
            5'd8:  c = (sx < sy);
            5'd9:  c = (x < y);
            5'd10: c = (x == y);
            5'd11: c = (x != y);
            5'd12: c = (sx >= sy);
            5'd13: c = (x >= y);
            5'd14: w = y;
            default: ;
        endcase
        if (op >= 5'd8 && op <= 5'd13) w = c ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0: return $urandom();
            1: return 32'($urandom_range(0, 40));
            2: return 32'h8000_0000 | 32'($urandom_range(0, 3));
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // expected ready for requester n, from the current model state and inputs
    function automatic logic exp_rdy(input int n);
        logic free;
        int   win;
        if (!rst_n) return 1'b0;
        free = !m_vld || rsp_ready;
        if (req0_valid && req1_valid) win = (m_last == 0) ? 1 : 0;
        else if (req0_valid)          win = 0;
        else if (req1_valid)          win = 1;
        else                          win = -1;
        return free && (win == n);
    endfunction

    task automatic model_reset();
        m_vld = 1'b0; m_id = 1'b0; m_w = 32'd0; m_cmp = 1'b0;
        m_last = 1; m_cnt0 = 16'd0; m_cnt1 = 16'd0;
    endtask

    // advance the model by one rising edge using the inputs now applied
    task automatic model_clock();
        logic [31:0] w;
        logic        c;
        if (exp_rdy(0)) begin
            alu_ref(req0_op, req0_x, req0_y, w, c);
            m_vld = 1'b1; m_id = 1'b0; m_w = w; m_cmp = c; m_cnt0 = m_cnt0 + 16'd1; m_last = 0;
        end else if (exp_rdy(1)) begin
            alu_ref(req1_op, req1_x, req1_y, w, c);
            m_vld = 1'b1; m_id = 1'b1; m_w = w; m_cmp = c; m_cnt1 = m_cnt1 + 16'd1; m_last = 1;
        end else if (rsp_ready) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                         input logic v1, input logic [4:0] o1, input logic [31:0] x1, input logic [31:0] y1,
                         input logic rr);
        req0_valid = v0; req0_op = o0; req0_x = x0; req0_y = y0;
        req1_valid = v1; req1_op = o1; req1_x = x1; req1_y = y1;
        rsp_ready = rr;
    endtask

    task automatic drive_idle();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(1'b1, 5'd0, 32'd5, 32'd6, 1'b1, 5'd0, 32'd7, 32'd8, 1'b1);
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
        n_cmp++; if (rsp_w !== 32'd0) begin n_err++; $display("FAIL reset_rsp_w got %h want 0", rsp_w); end
        n_cmp++; if (rsp_cmp !== 1'b0) begin n_err++; $display("FAIL reset_rsp_cmp got %b want 0", rsp_cmp); end
        n_cmp++; if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %h/%h want 0/0", grant_cnt0, grant_cnt1); end
        n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0 || grant_cnt0 !== 16'd0) begin n_err++; $display("FAIL reset_edge got v=%b c0=%h want 0/0", rsp_valid, grant_cnt0); end
        drive_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0] ew;
        logic        ec;
        drive(1'b1, 5'b00001, 32'd1, 32'd1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL single_ready got %b%b want 10", req0_ready, req1_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early got %b want 0", rsp_valid); end
        model_clock();
        @(posedge clk); #1;
        alu_ref(5'b00001, 32'd1, 32'd1, ew, ec);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin n_err++; $display("FAIL single_rsp got v=%b id=%b want 1/0", rsp_valid, rsp_id); end
        n_cmp++; if (rsp_w !== ew || rsp_cmp !== ec) begin n_err++; $display("FAIL single_w got %h/%b want %h/%b", rsp_w, rsp_cmp, ew, ec); end
        n_cmp++; if (grant_cnt0 !== 16'd1) begin n_err++; $display("FAIL single_cnt0 got %0d want 1", grant_cnt0); end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        @(negedge clk); model_clock();
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", rsp_valid); end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'($urandom_range(0, 14)), rand_val(), rand_val(),
                  1'b1, 5'($urandom_range(0, 14)), rand_val(), rand_val(), 1'b1);
            @(negedge clk);
            n_cmp++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                n_err++; $display("FAIL contend_ready[%0d] got %b%b", i, req0_ready, req1_ready); end
            model_clock();
            @(posedge clk); #1;
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2) || rsp_w !== m_w || rsp_cmp !== m_cmp) begin
                n_err++; $display("FAIL contend_rsp[%0d] got id=%b w=%h want id=%0d w=%h", i, rsp_id, rsp_w, i % 2, m_w); end
        end
        n_cmp++; if (grant_cnt0 !== 16'd4 || grant_cnt1 !== 16'd4) begin n_err++; $display("FAIL contend_cnt got %0d/%0d want 4/4", grant_cnt0, grant_cnt1); end
    endtask

    // slot holds requester 1's result here; requester 0 waits behind backpressure
    task automatic test_backpressure();
        logic [31:0] hold_w;
        logic        hold_id, hold_c;
        hold_w = m_w; hold_id = m_id; hold_c = m_cmp;
        drive(1'b1, 5'd0, 32'h10, 32'hF1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d] got %b%b want 00", i, req0_ready, req1_ready); end
            model_clock();
            @(posedge clk); #1;
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_w !== hold_w || rsp_id !== hold_id || rsp_cmp !== hold_c) begin
                n_err++; $display("FAIL bp_hold[%0d] got w=%h id=%b want w=%h id=%b", i, rsp_w, rsp_id, hold_w, hold_id); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", req0_ready); end
        model_clock();
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_w !== 32'h101 || rsp_id !== 1'b0) begin
            n_err++; $display("FAIL bp_new got v=%b w=%h id=%b want 1/00000101/0", rsp_valid, rsp_w, rsp_id); end
    endtask

    // slot full and requester 0 accepted last: requester 1 must win when it frees
    task automatic test_fairness();
        drive(1'b1, 5'd2, rand_val(), rand_val(), 1'b1, 5'd3, rand_val(), rand_val(), 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_err++; $display("FAIL fair_hold[%0d] got %b%b want 00", i, req0_ready, req1_ready); end
            model_clock();
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_err++; $display("FAIL fair_ready got %b%b want 01", req0_ready, req1_ready); end
        model_clock();
        @(posedge clk); #1;
        n_cmp++; if (rsp_id !== 1'b1 || rsp_w !== m_w) begin n_err++; $display("FAIL fair_rsp got id=%b w=%h want 1/%h", rsp_id, rsp_w, m_w); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'($urandom_range(0, 14)), rand_val(), rand_val(), 1'b1);
            @(negedge clk); model_clock();
            @(posedge clk); #1;
        end
        n_cmp++; if (grant_cnt1 !== 16'd5 || rsp_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre got c1=%0d v=%b want 5/1", grant_cnt1, rsp_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_w !== 32'd0 || rsp_cmp !== 1'b0) begin
            n_err++; $display("FAIL arst_rsp got v=%b id=%b w=%h c=%b want all 0", rsp_valid, rsp_id, rsp_w, rsp_cmp); end
        n_cmp++; if (grant_cnt1 !== 16'd0 || grant_cnt0 !== 16'd0) begin n_err++; $display("FAIL arst_cnt got %0d/%0d want 0/0", grant_cnt0, grant_cnt1); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL arst_ready got %b want 0", req1_ready); end
        model_reset();
        drive_idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b1, 5'd0, rand_val(), rand_val(), 1'b1, 5'd1, rand_val(), rand_val(), 1'b1);
        @(negedge clk);
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL arst_first got %b%b want 10", req0_ready, req1_ready); end
        model_clock();
        @(posedge clk); #1;
        n_cmp++; if (rsp_id !== 1'b0 || rsp_w !== m_w) begin n_err++; $display("FAIL arst_rsp_id got id=%b w=%h want 0/%h", rsp_id, rsp_w, m_w); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rand_val(), rand_val(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rand_val(), rand_val(),
                  1'($urandom_range(0, 9) < 7));
            @(negedge clk);
            n_cmp++; if (req0_ready !== exp_rdy(0) || req1_ready !== exp_rdy(1)) begin
                n_err++; $display("FAIL rand_ready[%0d] got %b%b want %b%b", i, req0_ready, req1_ready, exp_rdy(0), exp_rdy(1)); end
            model_clock();
            @(posedge clk); #1;
            n_cmp++; if (rsp_valid !== m_vld) begin n_err++; $display("FAIL rand_valid[%0d] got %b want %b", i, rsp_valid, m_vld); end
            if (m_vld) begin
                n_cmp++; if (rsp_id !== m_id || rsp_w !== m_w || rsp_cmp !== m_cmp) begin
                    n_err++; $display("FAIL rand_rsp[%0d] got %b/%h/%b want %b/%h/%b", i, rsp_id, rsp_w, rsp_cmp, m_id, m_w, m_cmp); end
            end
            n_cmp++; if (grant_cnt0 !== m_cnt0 || grant_cnt1 !== m_cnt1) begin
                n_err++; $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", i, grant_cnt0, grant_cnt1, m_cnt0, m_cnt1); end
        end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'd3, 32'd4, 1'b1);
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk); model_clock();
            @(posedge clk); #1;
            if (i == 65534) begin
                n_cmp++; if (grant_cnt1 !== 16'hFFFF) begin n_err++; $display("FAIL wrap_max got %h want ffff", grant_cnt1); end
            end
        end
        n_cmp++; if (grant_cnt1 !== 16'h0000) begin n_err++; $display("FAIL wrap_cnt1 got %h want 0000", grant_cnt1); end
        n_cmp++; if (grant_cnt0 !== 16'h0000) begin n_err++; $display("FAIL wrap_cnt0 got %h want 0000", grant_cnt0); end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_fairness();
        test_async_reset();
        test_random();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default `REG_FILE_WIDTH (32), data width of operands and result.
REQ-002 SHALL have parameter OPW, default 5, ALU opcode width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester 0/1 presents an operation.
REQ-006 req0_ready / req1_ready  output  1  operation accepted on this edge when paired valid is high.
REQ-007 req0_op / req1_op  input  OPW  ALU opcode.
REQ-008 req0_x, req0_y / req1_x, req1_y  input  WIDTH  ALU operands.
REQ-009 rsp_valid  output  1  result slot holds a result.
REQ-010 rsp_id  output  1  requester that issued the held result (0 or 1).
REQ-011 rsp_w  output  WIDTH  held ALU result.
REQ-012 rsp_cmp  output  1  held ALU compare flag.
REQ-013 rsp_ready  input  1  consumer takes the held result on this edge.
REQ-014 grant_cnt0 / grant_cnt1  output  16  accepted-request counters per requester.

Function
REQ-015 SHALL instantiate exactly one combinational alu (op, x, y, w, cmp) shared by both requesters.
REQ-016 SHALL hold one result slot: valid bit, id, w, cmp registers.
REQ-017 slot_free = ~rsp_valid | rsp_ready (slot empty or drained this edge).
REQ-018 Grant combinational: only one valid -> that requester; both valid -> requester != last_grant; none -> no grant.
REQ-019 reqN_ready = grantN & slot_free; never both readies high in one cycle.
REQ-020 Accept (reqN_valid & reqN_ready) SHALL drive ALU inputs from requester N and capture w, cmp, id=N into slot on that edge; rsp_valid=1 next cycle.
REQ-021 Latency: result visible exactly one cycle after accepting edge; throughput one op/cycle while rsp_ready held high.
REQ-022 Drain without new accept (rsp_valid & rsp_ready, no accept) SHALL clear rsp_valid.
REQ-023 Simultaneous drain and accept SHALL overwrite slot with new result, rsp_valid stays 1.
REQ-024 rsp_valid & ~rsp_ready SHALL hold rsp_id, rsp_w, rsp_cmp stable; both readies low.
REQ-025 last_grant SHALL update to N only on an accepting edge for requester N; a grant without acceptance (slot full) does not change it.
REQ-026 Requester inputs SHALL be don't-care when its valid is low; ALU input mux defaults to requester 0 when no grant.
REQ-027 grant_cntN SHALL increment by 1 on each accept by requester N, wrapping 16'hFFFF -> 16'h0000.
REQ-028 Requester may deassert valid without acceptance; no state change results.

Reset
REQ-029 rst_n low SHALL immediately force rsp_valid=0, rsp_id=0, rsp_w=0, rsp_cmp=0, grant_cnt0=grant_cnt1=0, last_grant=1 (requester 0 wins first contention).
REQ-030 Reset mid-operation SHALL discard slot contents; readies SHALL be low while rst_n low; first accept allowed on first rising edge after rst_n high.

Verification
REQ-031 Single request: req0_valid=1, op=5'b00001, x=1, y=1, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_w/rsp_cmp equal standalone alu for same inputs; grant_cnt0=1.
REQ-032 Contention after reset: both valid every cycle, rsp_ready=1 -> accepts alternate 0,1,0,1; after 8 cycles grant_cnt0=4, grant_cnt1=4.
REQ-033 Backpressure: slot full, rsp_ready=0 for 3 cycles, x=32'h10, y=32'hF1 pending -> both readies low, rsp_* stable 3 cycles; rsp_ready=1 -> pending accepted same edge, rsp_valid stays 1 with new result.
REQ-034 Fairness hold: slot full, both valid; last_grant=0 -> when slot frees, requester 1 accepted, not 0.
REQ-035 Async reset mid-stream: rst_n low between edges with rsp_valid=1, grant_cnt1=5 -> outputs clear without clock edge; after release requester 0 wins first contention.
REQ-036 Counter wrap: 65536 accepts by requester 1 -> grant_cnt1=0, grant_cnt0 unchanged.
